mst_ch_sched: RTL and testbench

Round-robin burst scheduler between the multi-channel streaming data generator and the FT601 master write path. It selects one enabled and ready channel and holds the grant for a programmed burst length. For each beat accepted downstream it pulses that channel's request line, which advances the generator. It muxes the selected channel's data onto a single write bus with byte enables set for 16- or 32-bit FIFO mode.

---
 rtl/mst_ch_sched_pkg.sv | 8 +
 rtl/mst_ch_sched_if.sv | 22 ++
 rtl/mst_rr_pick.sv | 21 ++
 rtl/mst_ch_sched.sv | 97 +++++++++
 tb/tb_mst_ch_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mst_ch_sched_pkg.sv
// mst_ch_sched_pkg: shared widths and scheduler state encoding
package mst_ch_sched_pkg;
  localparam int CNT_CHANNLS = 4;
  localparam int WIDTH_DATA  = 32;
  localparam int WIDTH_CH    = $clog2(CNT_CHANNLS);
  localparam int WIDTH_BE    = WIDTH_DATA / 8;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST, S_GAP} sched_state_t;
endpackage

// File: rtl/mst_ch_sched_if.sv
// mst_ch_sched_if: generator channel handshake plus FT601 write bus
interface mst_ch_sched_if;
  import mst_ch_sched_pkg::*;
  logic [CNT_CHANNLS-1:0] ch_en;
  logic [CNT_CHANNLS-1:0] ch_rdy;
  logic [WIDTH_DATA-1:0]  ch_dat [CNT_CHANNLS];
  logic                   ch_req [CNT_CHANNLS];
  logic                   wr_valid;
  logic                   wr_ready;
  logic [WIDTH_DATA-1:0]  wr_data;
  logic [WIDTH_BE-1:0]    wr_be;
  logic [WIDTH_CH-1:0]    wr_ch;
  logic                   wr_last;
  modport master (
    input  ch_en, ch_rdy, ch_dat, wr_ready,
    output ch_req, wr_valid, wr_data, wr_be, wr_ch, wr_last
  );
  modport slave (
    output ch_en, ch_rdy, ch_dat, wr_ready,
    input  ch_req, wr_valid, wr_data, wr_be, wr_ch, wr_last
  );
endinterface

// File: rtl/mst_rr_pick.sv
// mst_rr_pick: combinational circular priority picker starting after ptr
module mst_rr_pick
  import mst_ch_sched_pkg::*;
(
  input  logic [CNT_CHANNLS-1:0] req,
  input  logic [WIDTH_CH-1:0]    ptr,
  output logic [WIDTH_CH-1:0]    idx,
  output logic                   any
);
  logic [WIDTH_CH-1:0] j;
  // scan from the slot furthest from ptr down to ptr+1 so the nearest requester wins
  always_comb begin
    idx = '0;
    j   = '0;
    for (int k = CNT_CHANNLS; k >= 1; k--) begin
      j = WIDTH_CH'((int'(ptr) + k) % CNT_CHANNLS);
      if (req[j]) idx = j;
    end
    any = |req;
  end
endmodule

// File: rtl/mst_ch_sched.sv
// mst_ch_sched: round-robin burst scheduler from generator channels to the FT601 write path
module mst_ch_sched
  import mst_ch_sched_pkg::*;
#(
  parameter int WIDTH_BURST = 12,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bus16,
  input  logic [WIDTH_BURST-1:0] burst_len,
  mst_ch_sched_if.master         bus,
  output logic                   burst_abort,
  output logic                   busy
);
  localparam int WIDTH_GAP = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  sched_state_t           state_q, state_d;
  logic [WIDTH_CH-1:0]    sel_q, sel_d, rr_q, rr_d, pick;
  logic [WIDTH_BURST-1:0] cnt_q, cnt_d;
  logic [WIDTH_GAP-1:0]   gap_q, gap_d;
  logic                   abort_q, abort_d;
  logic                   any, en_sel, rdy_sel, accept, gap_end;

  mst_rr_pick u_pick (
    .req (bus.ch_en & bus.ch_rdy),
    .ptr (rr_q),
    .idx (pick),
    .any (any)
  );

  // state and burst bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      rr_q    <= WIDTH_CH'(CNT_CHANNLS - 1);
      cnt_q   <= '0;
      gap_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
    end
  end

  // next state: grant re-picks so a requester that vanished since IDLE yields no burst
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    abort_d = 1'b0;
    gap_end = GAP_CYCLES == 0 || int'(gap_q) >= GAP_CYCLES - 1;
    case (state_q)
      S_IDLE:  state_d = any ? S_GRANT : S_IDLE;
      S_GRANT: begin
        state_d = any ? S_BURST : S_IDLE;
        sel_d   = any ? pick : sel_q;
        cnt_d   = burst_len == '0 ? '0 : burst_len - 1'b1;
      end
      S_BURST: begin
        if (!en_sel || (accept && cnt_q == '0)) begin
          state_d = GAP_CYCLES == 0 ? S_IDLE : S_GAP;
          rr_d    = sel_q;
          gap_d   = '0;
          abort_d = !en_sel;
        end else if (accept) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = gap_end ? S_IDLE : S_GAP;
        gap_d   = gap_end ? '0 : gap_q + 1'b1;
      end
    endcase
  end

  // outputs: beat qualification, generator advance and data mux are combinational
  always_comb begin
    en_sel       = bus.ch_en[sel_q];
    rdy_sel      = bus.ch_rdy[sel_q];
    bus.wr_valid = state_q == S_BURST && en_sel && rdy_sel;
    accept       = bus.wr_valid && bus.wr_ready;
    bus.wr_last  = bus.wr_valid && cnt_q == '0;
    bus.wr_data  = bus.ch_dat[sel_q];
    bus.wr_ch    = sel_q;
    bus.wr_be    = bus16 ? WIDTH_BE'((1 << (WIDTH_DATA / 16)) - 1) : '1;
    for (int i = 0; i < CNT_CHANNLS; i++) bus.ch_req[i] = accept && sel_q == WIDTH_CH'(i);
    busy         = state_q != S_IDLE;
    burst_abort  = abort_q;
  end
endmodule

// File: tb/tb_mst_ch_sched.sv
// tb_mst_ch_sched: scenario tests of the burst scheduler against rule-based expectations
module tb_mst_ch_sched;
  import mst_ch_sched_pkg::*;
  localparam int G = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus16 = 1'b0;
  logic [11:0] burst_len = '0;
  logic        burst_abort, busy;
  logic [31:0] gen [4];
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic v, r, last, ab, busy;
    logic [31:0] d;
    logic [1:0] ch;
    logic [3:0] req, be;
  } obs_t;
  obs_t        lg [$];
  int          bi [$];
  logic [31:0] bd [$];
  logic [1:0]  bch [$];
  logic        bl [$];

  mst_ch_sched_if bus ();
  mst_ch_sched #(.WIDTH_BURST(12), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .bus16(bus16), .burst_len(burst_len),
    .bus(bus), .burst_abort(burst_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  // free-running per-channel counters standing in for the data generator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 4; i++) gen[i] <= '1;
    else for (int i = 0; i < 4; i++) if (bus.ch_req[i]) gen[i] <= gen[i] + 1;
  end
  always_comb for (int i = 0; i < 4; i++) bus.ch_dat[i] = gen[i];

  task automatic tick();
    obs_t o;
    @(negedge clk);
    o.v = bus.wr_valid; o.r = bus.wr_ready; o.last = bus.wr_last; o.ab = burst_abort;
    o.busy = busy; o.d = bus.wr_data; o.ch = bus.wr_ch; o.be = bus.wr_be;
    for (int i = 0; i < 4; i++) o.req[i] = bus.ch_req[i];
    lg.push_back(o);
    @(posedge clk);
    #1;
  endtask

  function automatic int nbeats();
    int n = 0;
    foreach (lg[k]) n += int'(lg[k].v && lg[k].r);
    return n;
  endfunction

  task automatic get_beats();
    bi.delete(); bd.delete(); bch.delete(); bl.delete();
    foreach (lg[k]) if (lg[k].v && lg[k].r) begin
      bi.push_back(k); bd.push_back(lg[k].d); bch.push_back(lg[k].ch); bl.push_back(lg[k].last);
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int c = 0;
    while (nbeats() < n && c < budget) begin tick(); c++; end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.ch_en = '0; bus.ch_rdy = '0; bus.wr_ready = 1'b0; bus16 = 1'b0; burst_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lg.delete();
  endtask

  task automatic test_reset();
    logic [3:0] rq;
    rst = 1'b1; bus.ch_en = '1; bus.ch_rdy = '1; bus.wr_ready = 1'b1; burst_len = 12'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) rq[i] = bus.ch_req[i];
    n_chk++; if ({bus.wr_valid, bus.wr_last, burst_abort, busy} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got v/l/ab/busy=%b want 0000", {bus.wr_valid, bus.wr_last, burst_abort, busy}); end
    n_chk++; if (rq !== 4'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0000", rq); end
    n_chk++; if (bus.wr_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", bus.wr_ch); end
    n_chk++; if (bus.wr_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_data: got %h want ffffffff", bus.wr_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    lg.delete();
    repeat (3) tick();
    n_chk++; if ({lg[0].v, lg[0].busy} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got v/busy=%b want 00", {lg[0].v, lg[0].busy}); end
    n_chk++; if ({lg[1].v, lg[1].busy} !== 2'b01) begin n_fail++; $display("FAIL reset_grant: got v/busy=%b want 01", {lg[1].v, lg[1].busy}); end
    n_chk++; if ({lg[2].v, lg[2].ch} !== 3'b100) begin n_fail++; $display("FAIL reset_first_ch: got v/ch=%b want 100", {lg[2].v, lg[2].ch}); end
  endtask

  task automatic test_single();
    int nreq = 0;
    logic [31:0] e;
    do_reset();
    burst_len = 12'd4; bus.wr_ready = 1'b1; bus.ch_rdy = '1; bus.ch_en = 4'b0001;
    repeat (10) tick();
    for (int k = 0; k < 10; k++) begin
      n_chk++; if (lg[k].v !== (k >= 2 && k <= 5)) begin n_fail++; $display("FAIL single_valid[%0d]: got %b want %b", k, lg[k].v, k >= 2 && k <= 5); end
      n_chk++; if (lg[k].last !== (k == 5)) begin n_fail++; $display("FAIL single_last[%0d]: got %b want %b", k, lg[k].last, k == 5); end
      nreq += int'(lg[k].req[0]) + 2 * int'(|lg[k].req[3:1]);
    end
    for (int k = 2; k <= 5; k++) begin
      e = 32'hFFFF_FFFF + 32'(k - 2);
      n_chk++; if (lg[k].d !== e) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", k - 2, lg[k].d, e); end
    end
    n_chk++; if (nreq != 4) begin n_fail++; $display("FAIL single_req_count: got %0d want 4", nreq); end
    n_chk++; if ({lg[6].busy, lg[7].busy, lg[8].busy} !== 3'b110) begin n_fail++; $display("FAIL single_gap_busy: got %b want 110", {lg[6].busy, lg[7].busy, lg[8].busy}); end
  endtask

  task automatic test_round_robin();
    logic [31:0] eg [4];
    do_reset();
    bus.ch_en = '1; bus.ch_rdy = '1; burst_len = 12'd2; bus.wr_ready = 1'b1;
    run_until(10, 100);
    n_chk++; if (nbeats() < 10) begin n_fail++; $display("FAIL rr_timeout: got %0d beats want 10", nbeats()); end
    get_beats();
    for (int i = 0; i < 4; i++) eg[i] = '1;
    for (int b = 0; b < bd.size() && b < 10; b++) begin
      n_chk++; if (bch[b] !== 2'((b / 2) % 4)) begin n_fail++; $display("FAIL rr_ch[%0d]: got %0d want %0d", b, bch[b], (b / 2) % 4); end
      n_chk++; if (bd[b] !== eg[bch[b]]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", b, bd[b], eg[bch[b]]); end
      eg[bch[b]] = eg[bch[b]] + 1;
      n_chk++; if (bl[b] !== (b % 2 == 1)) begin n_fail++; $display("FAIL rr_last[%0d]: got %b want %b", b, bl[b], b % 2 == 1); end
      if (b % 2 == 0 && b > 0) begin
        n_chk++; if (bi[b] - bi[b - 1] != G + 3) begin n_fail++; $display("FAIL rr_turnaround[%0d]: got %0d want %0d", b, bi[b] - bi[b - 1], G + 3); end
      end
    end
  endtask

  task automatic test_stall();
    int c = $urandom_range(0, 3);
    int s0, nreq = 0;
    do_reset();
    bus.ch_en = 4'(1 << c); bus.ch_rdy = '1; bus.wr_ready = 1'b1; burst_len = 12'd3;
    run_until(1, 10);
    n_chk++; if (nbeats() != 1) begin n_fail++; $display("FAIL stall_first_beat: got %0d beats want 1", nbeats()); end
    bus.ch_rdy = 4'hF ^ 4'(1 << c);
    s0 = lg.size();
    repeat (5) tick();
    for (int k = s0; k < s0 + 5; k++) begin
      n_chk++; if ({lg[k].v, lg[k].req, lg[k].busy} !== 6'b000001) begin n_fail++; $display("FAIL stall_cycle[%0d]: got v/req/busy=%b want 000001", k - s0, {lg[k].v, lg[k].req, lg[k].busy}); end
    end
    bus.ch_rdy = '1;
    run_until(3, 10);
    get_beats();
    n_chk++; if (bd.size() != 3) begin n_fail++; $display("FAIL stall_beats: got %0d want 3", bd.size()); end
    for (int b = 0; b < bd.size(); b++) begin
      n_chk++; if ({bd[b], bch[b], bl[b]} !== {32'hFFFF_FFFF + 32'(b), 2'(c), b == 2}) begin n_fail++; $display("FAIL stall_beat[%0d]: got d=%h ch=%0d last=%b want d=%h ch=%0d last=%b", b, bd[b], bch[b], bl[b], 32'hFFFF_FFFF + 32'(b), c, b == 2); end
    end
    foreach (lg[k]) nreq += $countones(lg[k].req);
    n_chk++; if (nreq != 3) begin n_fail++; $display("FAIL stall_req_count: got %0d want 3", nreq); end
  endtask

  task automatic test_backpressure();
    int c = $urandom_range(0, 3);
    int len = $urandom_range(3, 6);
    int cyc = 0;
    logic [3:0] er;
    do_reset();
    bus.ch_en = 4'(1 << c); bus.ch_rdy = '1; burst_len = 12'(len);
    while (nbeats() < len && cyc < 60) begin bus.wr_ready = cyc % 2 == 0; tick(); cyc++; end
    n_chk++; if (nbeats() != len) begin n_fail++; $display("FAIL bp_timeout: got %0d beats want %0d", nbeats(), len); end
    foreach (lg[k]) begin
      er = (lg[k].v && lg[k].r) ? 4'(1 << c) : 4'b0;
      n_chk++; if (lg[k].req !== er) begin n_fail++; $display("FAIL bp_req[%0d]: got %b want %b", k, lg[k].req, er); end
      if (lg[k].v && !lg[k].r && k + 1 < lg.size()) begin
        n_chk++; if (lg[k + 1].d !== lg[k].d) begin n_fail++; $display("FAIL bp_data_hold[%0d]: got %h want %h", k, lg[k + 1].d, lg[k].d); end
      end
    end
    get_beats();
    for (int b = 0; b < bd.size(); b++) begin
      n_chk++; if ({bd[b], bl[b]} !== {32'hFFFF_FFFF + 32'(b), b == len - 1}) begin n_fail++; $display("FAIL bp_beat[%0d]: got d=%h last=%b want d=%h last=%b", b, bd[b], bl[b], 32'hFFFF_FFFF + 32'(b), b == len - 1); end
    end
  endtask

  task automatic test_abort();
    int s0, nab = 0, nlast = 0;
    do_reset();
    bus.ch_en = 4'b0110; bus.ch_rdy = '1; bus.wr_ready = 1'b1; burst_len = 12'd8;
    run_until(2, 10);
    n_chk++; if (nbeats() != 2) begin n_fail++; $display("FAIL abort_pre_beats: got %0d want 2", nbeats()); end
    bus.ch_en = 4'b0100;
    s0 = lg.size();
    run_until(3, 20);
    get_beats();
    n_chk++; if (bd.size() != 3) begin n_fail++; $display("FAIL abort_next_timeout: got %0d beats want 3", bd.size()); end
    n_chk++; if ({lg[s0].v, lg[s0 + 1].ab} !== 2'b01) begin n_fail++; $display("FAIL abort_pulse: got v/ab=%b want 01", {lg[s0].v, lg[s0 + 1].ab}); end
    foreach (lg[k]) begin nab += int'(lg[k].ab); nlast += int'(lg[k].last); end
    n_chk++; if (nab != 1) begin n_fail++; $display("FAIL abort_pulse_count: got %0d want 1", nab); end
    n_chk++; if (nlast != 0) begin n_fail++; $display("FAIL abort_last: got %0d want 0", nlast); end
    if (bd.size() == 3) begin
      n_chk++; if ({bch[0], bch[1], bd[1]} !== {2'd1, 2'd1, 32'h0}) begin n_fail++; $display("FAIL abort_ch1_beats: got ch=%0d,%0d d=%h want 1,1 d=0", bch[0], bch[1], bd[1]); end
      n_chk++; if ({bch[2], bd[2]} !== {2'd2, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL abort_next_grant: got ch=%0d d=%h want ch=2 d=ffffffff", bch[2], bd[2]); end
      n_chk++; if (bi[2] != s0 + G + 3) begin n_fail++; $display("FAIL abort_turnaround: got %0d want %0d", bi[2] - s0, G + 3); end
    end
  endtask

  task automatic test_bus16();
    int c = $urandom_range(0, 3);
    logic [3:0] rq;
    do_reset();
    bus16 = 1'b1; burst_len = 12'd0; bus.ch_en = 4'(1 << c); bus.ch_rdy = '1; bus.wr_ready = 1'b1;
    repeat (7) tick();
    get_beats();
    n_chk++; if (bd.size() != 1) begin n_fail++; $display("FAIL b16_beats: got %0d want 1", bd.size()); end
    n_chk++; if ({lg[2].v, lg[2].last, lg[2].be, lg[2].ch} !== {1'b1, 1'b1, 4'b0011, 2'(c)}) begin n_fail++; $display("FAIL b16_beat: got v=%b last=%b be=%b ch=%0d want 1 1 0011 %0d", lg[2].v, lg[2].last, lg[2].be, lg[2].ch, c); end
    n_chk++; if (lg[0].be !== 4'b0011) begin n_fail++; $display("FAIL b16_be_idle: got %b want 0011", lg[0].be); end
    do_reset();
    burst_len = 12'd8; bus.ch_en = 4'(1 << c); bus.ch_rdy = '1; bus.wr_ready = 1'b1;
    run_until(3, 10);
    n_chk++; if (nbeats() != 3) begin n_fail++; $display("FAIL midrst_pre_beats: got %0d want 3", nbeats()); end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) rq[i] = bus.ch_req[i];
    n_chk++; if ({bus.wr_valid, busy, bus.wr_last, rq} !== 7'b0) begin n_fail++; $display("FAIL midrst_outputs: got v/busy/last/req=%b want 0000000", {bus.wr_valid, busy, bus.wr_last, rq}); end
    n_chk++; if (bus.wr_be !== 4'b1111) begin n_fail++; $display("FAIL midrst_be32: got %b want 1111", bus.wr_be); end
  endtask

  initial begin
    bus.ch_en = '0; bus.ch_rdy = '0; bus.wr_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_backpressure();
    test_abort();
    test_bus16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
